basamak_tarayici: RTL and testbench



---
 rtl/basamak_tarayici.sv | 138 +++++++++++++
 tb/tb_basamak_tarayici.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/basamak_tarayici.sv
// basamak_tarayici: sequential leading-one finder.
// Captures a word on start and scans it one nibble per clock, from the most
// significant nibble down. It then reports the index of the highest set bit
// and an all-zero flag.
//
// Define BASAMAK_EARLY_EXIT_EN to end the scan at the first non-zero nibble.
// Without it, the scan always covers every nibble, so latency is fixed.
//
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   start   - scan request, sampled only while idle
//   sayi    - word to scan, captured on the accepting edge
//   busy    - high while a scan is in progress (registered)
//   done    - one-cycle pulse when results are valid (registered)
//   basamak - index of the highest set bit, 0 = LSB (registered)
//   sifir   - captured word was all zero (registered)
module basamak_tarayici #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [4*NIBBLES-1:0]              sayi,
  output logic                              busy,
  output logic                              done,
  output logic [$clog2(4*NIBBLES)-1:0]      basamak,
  output logic                              sifir
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned POS_W = $clog2(W);
  localparam int unsigned IDX_W = $clog2(NIBBLES);

`ifdef BASAMAK_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [W-1:0]     word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             found_q, found_d;
  logic [POS_W-1:0] cand_q, cand_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [POS_W-1:0] basamak_q, basamak_d;
  logic             sifir_q, sifir_d;

  logic [3:0]       nib;
  logic [1:0]       hb;
  logic             found_now;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      idx_q     <= '0;
      found_q   <= 1'b0;
      cand_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      basamak_q <= '0;
      sifir_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      found_q   <= found_d;
      cand_q    <= cand_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      basamak_q <= basamak_d;
      sifir_q   <= sifir_d;
    end
  end

  // Next-state, nibble examination and result staging.
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    idx_d     = idx_q;
    found_d   = found_q;
    cand_d    = cand_q;
    done_d    = 1'b0;
    basamak_d = basamak_q;
    sifir_d   = sifir_q;

    nib = 4'(word_q >> {idx_q, 2'b00});
    casez (nib)
      4'b1???: hb = 2'd3;
      4'b01??: hb = 2'd2;
      4'b001?: hb = 2'd1;
      default: hb = 2'd0;
    endcase
    // Only the first non-zero nibble (the highest one) may set the candidate.
    found_now = !found_q && (nib != 4'd0);

    case (state_q)
      IDLE: begin
        if (start) begin
          word_d  = sayi;
          idx_d   = IDX_W'(NIBBLES - 1);
          found_d = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        found_d = found_q | found_now;
        if (found_now) begin
          cand_d = POS_W'({idx_q, hb});
        end
        if ((idx_q == '0) || (EARLY_EXIT && found_now)) begin
          done_d    = 1'b1;
          basamak_d = found_d ? cand_d : '0;
          sifir_d   = !found_d;
          state_d   = IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SCAN);
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign basamak = basamak_q;
  assign sifir   = sifir_q;

endmodule

// File: tb/tb_basamak_tarayici.sv
// Testbench for basamak_tarayici (default NIBBLES=4).
// Compares the DUT against a reference model that searches the word bit by bit.
// Works in both builds; define BASAMAK_EARLY_EXIT_EN here as well for the
// early-exit variant.
module tb_basamak_tarayici;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 4 * N;
  localparam int unsigned PW = $clog2(W);

`ifdef BASAMAK_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  sayi;
  logic          busy;
  logic          done;
  logic [PW-1:0] basamak;
  logic          sifir;

  int tests = 0;
  int fails = 0;
  logic [PW-1:0] prev_bas;
  logic          prev_sif;

  basamak_tarayici #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sayi(sayi),
    .busy(busy), .done(done), .basamak(basamak), .sifir(sifir)
  );

  always #5 clk = ~clk;

  function automatic int ref_pos(input logic [W-1:0] w);
    for (int i = int'(W) - 1; i >= 0; i--) if (w[i]) return i;
    return 0;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] w);
    if (EARLY && (w != '0)) return int'(N) - ref_pos(w) / 4;
    return int'(N);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the done edge.
  task automatic do_scan(input logic [W-1:0] w, input bit poke, input string tag);
    int lat;
    bit got;
    start = 1'b1;
    sayi  = w;
    @(posedge clk); #1;
    start = 1'b0;
    sayi  = W'($urandom);
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    chk({tag, "_done_low"}, 32'(done), 32'd0);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      if (poke && lat == 1) begin
        start = 1'b1;
        sayi  = 16'hFFFF;
      end else if (poke && lat == 2) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      chk({tag, "_done_busy_excl"}, 32'(done & busy), 32'd0);
      if (done) got = 1'b1;
      else begin
        chk({tag, "_hold_bas"}, 32'(basamak), 32'(prev_bas));
        chk({tag, "_hold_sif"}, 32'(sifir), 32'(prev_sif));
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(ref_lat(w)));
    chk({tag, "_basamak"}, 32'(basamak), 32'(ref_pos(w)));
    chk({tag, "_sifir"}, 32'(sifir), 32'(w == '0));
    prev_bas = PW'(ref_pos(w));
    prev_sif = (w == '0);
  endtask

  initial begin
    logic [W-1:0] r;
    rst_n    = 1'b0;
    start    = 1'b0;
    sayi     = '0;
    prev_bas = '0;
    prev_sif = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_basamak", 32'(basamak), 32'd0);
    chk("rst_sifir", 32'(sifir), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_scan(16'h0000, 1'b0, "zero");
    do_scan(16'h8000, 1'b0, "msb");
    do_scan(16'h0300, 1'b0, "x0300");
    do_scan(16'h0001, 1'b0, "lsb");
    // Start during busy is ignored; the next start lands in the done cycle.
    do_scan(16'h0010, 1'b1, "ignore_busy");
    do_scan(16'hFFFF, 1'b0, "b2b");

    for (int i = 0; i < 40; i++) begin
      r = W'($urandom);
      // Mix in sparse words so that every nibble position gets the top bit.
      case (i % 4)
        0: r = r >> $urandom_range(0, W - 1);
        1: r = r & W'(16'h000F << (4 * $urandom_range(0, N - 1)));
        default: ;
      endcase
      do_scan(r, 1'b0, "rand");
    end

    do_scan(16'h0F00, 1'b0, "pre_rst");

    // A reset mid-scan aborts the scan and clears the outputs at once.
    start = 1'b1;
    sayi  = 16'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_basamak", 32'(basamak), 32'd0);
    chk("midrst_sifir", 32'(sifir), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_done", 32'(done), 32'd0);
    end
    prev_bas = '0;
    prev_sif = 1'b0;
    do_scan(16'h0040, 1'b0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
